// File: rtl/risc_datapath.sv
// Datapath for the 8-bit accumulator RISC: 32x8 memory, IR, PC, AC, operand register and ALU,
// sequenced by a free-running phase counter. Optional strobe checker under DP_PROTOCOL_CHK_EN.
module risc_datapath (
  input  logic       clk,
  input  logic       rst_,
  input  logic       mem_rd,
  input  logic       load_ir,
  input  logic       halt,
  input  logic       inc_pc,
  input  logic       load_ac,
  input  logic       load_pc,
  input  logic       mem_wr,
  input  logic       prog_we,
  input  logic [4:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic [2:0] opcode,
  output logic       zero,
  output logic [4:0] pc,
  output logic [7:0] ac,
  output logic       halted,
  output logic       proto_err
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_LDA = 3'b011;
  localparam logic [2:0] OP_JMP = 3'b101;

  localparam logic [2:0] PH_OP_FETCH = 3'd5;
  localparam logic [2:0] PH_ALU_OP   = 3'd6;

  logic [2:0]  phase;
  logic [7:0]  ir, opnd, alu_res, rdata;
  logic [4:0]  addr;
  logic [31:0][7:0] mem;
  logic        run;

  assign run    = !halted;
  assign opcode = ir[7:5];
  assign zero   = (ac == 8'h00);
  // first half of the instruction addresses via PC, second half via the IR operand field
  assign addr   = phase[2] ? ir[4:0] : pc;
  assign rdata  = mem_rd ? mem[addr] : 8'h00;

  always_comb begin
    alu_res = ac;
    case (opcode)
      OP_ADD:  alu_res = ac + opnd;
      OP_AND:  alu_res = ac & opnd;
      OP_XOR:  alu_res = ac ^ opnd;
      OP_LDA:  alu_res = opnd;
      default: alu_res = ac;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase  <= '0;
      halted <= 1'b0;
      ir     <= '0;
      opnd   <= '0;
      ac     <= '0;
      pc     <= '0;
    end else begin
      phase <= phase + 3'd1;
      if (halt) halted <= 1'b1;
      // strobes arriving with halt still land; halted gates from the next cycle on
      if (run) begin
        if (load_ir) ir <= rdata;
        if (load_ac && phase == PH_OP_FETCH) opnd <= rdata;
        if (load_ac && phase == PH_ALU_OP)   ac   <= alu_res;
        if (inc_pc)                          pc   <= pc + 5'd1;
        else if (load_pc && opcode == OP_JMP) pc  <= ir[4:0];
      end
    end
  end

  // memory is not reset; boot writes take priority over STO on an address clash
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (prog_we && prog_addr == 5'(i))           mem[i] <= prog_data;
      else if (run && mem_wr && ir[4:0] == 5'(i)) mem[i] <= ac;
    end
  end

`ifdef DP_PROTOCOL_CHK_EN
  logic viol;
  assign viol = (mem_rd && mem_wr)
             || (load_ir && phase != 3'd2)
             || (mem_wr  && phase != 3'd7)
             || (load_pc && phase != PH_ALU_OP);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)     proto_err <= 1'b0;
    else if (viol) proto_err <= 1'b1;
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_risc_datapath.sv
// Directed bench for risc_datapath: program load, LDA/ADD/JMP/SKZ/STO, PC wrap, halt and reset.
module tb_risc_datapath;
  logic       clk = 1'b0;
  logic       rst_;
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic [2:0] opcode;
  logic       zero;
  logic [4:0] pc;
  logic [7:0] ac;
  logic       halted, proto_err;

  int total = 0;
  int bad   = 0;
  int ph    = 0;

  always #5 clk = ~clk;

  risc_datapath dut (
    .clk(clk), .rst_(rst_), .mem_rd(mem_rd), .load_ir(load_ir), .halt(halt),
    .inc_pc(inc_pc), .load_ac(load_ac), .load_pc(load_pc), .mem_wr(mem_wr),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .zero(zero), .pc(pc), .ac(ac), .halted(halted),
    .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock with the given strobes; halt/prog_we are one-shot
  task automatic step(input logic rd, input logic lir, input logic lac,
                      input logic inc, input logic lpc, input logic wr);
    mem_rd = rd; load_ir = lir; load_ac = lac; inc_pc = inc; load_pc = lpc; mem_wr = wr;
    @(posedge clk); #1;
    ph = (ph + 1) % 8;
    mem_rd = 0; load_ir = 0; load_ac = 0; inc_pc = 0; load_pc = 0; mem_wr = 0;
    halt = 0; prog_we = 0;
  endtask

  task automatic fetch();
    if (ph != 0) begin
      bad++; total++;
      $display("FAIL phase_align: got %0d expected 0", ph);
    end
    step(0,0,0,0,0,0);
    step(1,0,0,0,0,0);
    step(1,1,0,0,0,0);
    step(0,0,0,1,0,0);
  endtask

  task automatic exec_lda();
    fetch();
    step(0,0,0,0,0,0);
    step(1,0,1,0,0,0);
    step(1,0,1,0,0,0);
    step(0,0,0,0,0,0);
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 0;
  endtask

  initial begin
    rst_ = 0; halt = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    mem_rd = 0; load_ir = 0; load_ac = 0; inc_pc = 0; load_pc = 0; mem_wr = 0;
    #2;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_ac", 32'(ac), 0);
    chk("rst_opcode", 32'(opcode), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_proto", 32'(proto_err), 0);

    load(0, 8'h7E);  load(30, 8'h05);   // LDA 30
    load(1, 8'h7D);  load(29, 8'hFF);   // LDA 29
    load(2, 8'h1F);  load(31, 8'h02);   // ADD 31
    load(3, 8'hA9);                     // JMP 9
    load(9, 8'h7C);  load(28, 8'h00);   // LDA 28
    load(10, 8'hC0); load(12, 8'hC0);   // SKZ, SKZ
    load(13, 8'h7B); load(27, 8'h3C);   // LDA 27
    load(14, 8'h85); load(15, 8'h65);   // STO 5, LDA 5
    load(16, 8'h86); load(17, 8'h66);   // STO 6, LDA 6
    load(18, 8'hBF);                    // JMP 31
    rst_ = 1; ph = 0;

    // LDA 30
    fetch();
    chk("lda_pc", 32'(pc), 1);
    chk("lda_opcode", 32'(opcode), 3);
    step(0,0,0,0,0,0); step(1,0,1,0,0,0); step(1,0,1,0,0,0);
    chk("lda_ac", 32'(ac), 8'h05);
    chk("lda_zero", 32'(zero), 0);
    step(0,0,0,0,0,0);

    exec_lda();
    chk("lda_ff", 32'(ac), 8'hFF);

    // ADD 31: AC changes only at phase 6
    fetch(); step(0,0,0,0,0,0);
    step(1,0,1,0,0,0);
    chk("add_ph5_hold", 32'(ac), 8'hFF);
    step(1,0,1,0,0,0);
    chk("add_wrap", 32'(ac), 8'h01);
    step(1,0,1,0,0,0);
    chk("add_ph7_hold", 32'(ac), 8'h01);

    // JMP 9
    fetch();
    chk("jmp_inc", 32'(pc), 4);
    step(0,0,0,0,0,0); step(0,0,0,0,0,0);
    step(0,0,0,0,1,0);
    chk("jmp_pc", 32'(pc), 9);
    step(0,0,0,0,0,0);

    exec_lda();
    chk("lda_zero_ac", 32'(ac), 0);
    chk("zero_flag", 32'(zero), 1);

    // SKZ taken
    fetch(); step(0,0,0,0,0,0); step(0,0,0,0,0,0);
    step(0,0,0,1,1,0);
    chk("skz_taken", 32'(pc), 12);
    step(0,0,0,0,0,0);

    // SKZ with load_pc alone
    fetch(); step(0,0,0,0,0,0); step(0,0,0,0,0,0);
    step(0,0,0,0,1,0);
    chk("skz_hold", 32'(pc), 13);
    step(0,0,0,0,0,0);

    exec_lda();
    chk("lda_3c", 32'(ac), 8'h3C);

    // STO 5, read back
    fetch(); step(0,0,0,0,0,0); step(0,0,0,0,0,0); step(0,0,0,0,0,0);
    step(0,0,0,0,0,1);
    exec_lda();
    chk("sto_mem5", 32'(ac), 8'h3C);

    // STO 6 with coincident boot write: boot data wins
    fetch(); step(0,0,0,0,0,0); step(0,0,0,0,0,0); step(0,0,0,0,0,0);
    prog_we = 1; prog_addr = 6; prog_data = 8'h5A;
    step(0,0,0,0,0,1);
    exec_lda();
    chk("prog_wins", 32'(ac), 8'h5A);

    // JMP 31 then PC wrap
    fetch(); step(0,0,0,0,0,0); step(0,0,0,0,0,0);
    step(0,0,0,0,1,0);
    chk("jmp31", 32'(pc), 31);
    step(0,0,0,0,0,0);
    fetch();
    chk("pc_wrap", 32'(pc), 0);
    repeat (4) step(0,0,0,0,0,0);

    // halt at phase 4, then blocked strobes
    fetch();
    halt = 1;
    step(0,0,0,0,0,0);
    chk("halted_set", 32'(halted), 1);
    step(1,0,1,1,0,0);
    chk("halt_ac5", 32'(ac), 8'h5A);
    chk("halt_pc", 32'(pc), 1);
    step(1,0,1,0,0,0);
    chk("halt_ac6", 32'(ac), 8'h5A);
    prog_we = 1; prog_addr = 1; prog_data = 8'h7B;
    step(0,0,0,0,0,1);
    repeat (5) step(0,0,0,1,0,0);
    chk("halt_pc_late", 32'(pc), 1);
    chk("halted_sticky", 32'(halted), 1);

    // reset pulse in the middle of phase 5
    #2 rst_ = 0;
    #1;
    chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_halted", 32'(halted), 0);
    chk("mid_rst_zero", 32'(zero), 1);
    @(posedge clk); #1;
    rst_ = 1; ph = 0;

    exec_lda();
    chk("sto_blocked", 32'(ac), 8'h05);
    chk("post_rst_pc", 32'(pc), 1);
    exec_lda();
    chk("prog_in_halt", 32'(ac), 8'h3C);

    // mem_rd with mem_wr during phase 3
    chk("proto_clean", 32'(proto_err), 0);
    step(0,0,0,0,0,0); step(0,0,0,0,0,0); step(0,0,0,0,0,0);
    step(1,0,0,0,0,1);
`ifdef DP_PROTOCOL_CHK_EN
    chk("proto_set", 32'(proto_err), 1);
    step(0,0,0,0,0,0);
    chk("proto_sticky", 32'(proto_err), 1);
`else
    chk("proto_tied", 32'(proto_err), 0);
    step(0,0,0,0,0,0);
    chk("proto_tied2", 32'(proto_err), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
